// File: rtl/axis_sa_out_transpose.sv
// axis_sa_out_transpose
// Collects one R x C result tile from axis_sa, which arrives as C column beats
// with the last column first. The tile is then replayed row-major as R row
// beats, with row 0 first and column 0 in lane 0. A single tile buffer is used,
// so filling and draining never overlap.

module axis_sa_out_transpose #(
  parameter int R  = 2,
  parameter int C  = 2,
  parameter int WY = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic                   s_last,
  input  logic [R-1:0][WY-1:0]   s_data,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic                   m_last,
  output logic [C-1:0][WY-1:0]   m_data,
  output logic                   tile_err
);

  localparam int CW = $clog2((C > 2) ? C : 2);
  localparam int RW = $clog2((R > 2) ? R : 2);

  localparam logic [0:0] FILL  = 1'b0;
  localparam logic [0:0] DRAIN = 1'b1;

  logic [0:0]                  state_q, state_d;
  logic [CW-1:0]               col_cnt_q, col_cnt_d;
  logic [RW-1:0]               row_cnt_q, row_cnt_d;
  logic                        tile_err_q, tile_err_d;
  logic [R-1:0][C-1:0][WY-1:0] tile_q;

  logic                        s_hs;
  logic                        m_hs;
  logic                        last_col;
  logic                        last_row;
  int                          col_idx;
  logic [C-1:0]                wr_col;
  logic [C-1:0]                zero_col;

  assign s_ready  = (state_q == FILL) && !rst;
  assign m_valid  = (state_q == DRAIN);
  assign s_hs     = s_valid && s_ready;
  assign m_hs     = m_valid && m_ready;
  assign last_col = (col_cnt_q == CW'(C - 1));
  assign last_row = (row_cnt_q == RW'(R - 1));
  assign col_idx  = int'(col_cnt_q);
  assign m_last   = m_valid && last_row;
  assign m_data   = tile_q[row_cnt_q];
  assign tile_err = tile_err_q;

  // Beat j is stored into column C-1-j. An early s_last also clears every
  // column that the missing beats would have filled.
  always_comb begin
    wr_col   = '0;
    zero_col = '0;
    for (int k = 0; k < C; k++) begin
      if (s_hs) begin
        if (k == C - 1 - col_idx) begin
          wr_col[k] = 1'b1;
        end else if (s_last && (k < C - 1 - col_idx)) begin
          zero_col[k] = 1'b1;
        end
      end
    end
  end

  // The tile buffer has no reset because its contents only matter after a
  // complete fill.
  always_ff @(posedge clk) begin
    for (int r = 0; r < R; r++) begin
      for (int k = 0; k < C; k++) begin
        if (wr_col[k]) begin
          tile_q[r][k] <= s_data[r];
        end else if (zero_col[k]) begin
          tile_q[r][k] <= '0;
        end
      end
    end
  end

  // Fill/drain sequencing. A tile ends on s_last or on the C-th beat,
  // whichever comes first. Any disagreement between the two sets the sticky
  // error flag.
  always_comb begin
    state_d    = state_q;
    col_cnt_d  = col_cnt_q;
    row_cnt_d  = row_cnt_q;
    tile_err_d = tile_err_q;
    case (state_q)
      FILL: begin
        if (s_hs) begin
          if (s_last != last_col) begin
            tile_err_d = 1'b1;
          end
          if (s_last || last_col) begin
            state_d   = DRAIN;
            col_cnt_d = '0;
          end else begin
            col_cnt_d = col_cnt_q + CW'(1);
          end
        end
      end
      DRAIN: begin
        if (m_hs) begin
          if (last_row) begin
            row_cnt_d = '0;
            state_d   = FILL;
          end else begin
            row_cnt_d = row_cnt_q + RW'(1);
          end
        end
      end
      default: begin
        state_d = FILL;
      end
    endcase
  end

  // Control registers. A reset aborts any tile in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FILL;
      col_cnt_q  <= '0;
      row_cnt_q  <= '0;
      tile_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      col_cnt_q  <= col_cnt_d;
      row_cnt_q  <= row_cnt_d;
      tile_err_q <= tile_err_d;
    end
  end

endmodule

// File: tb/tb_axis_sa_out_transpose.sv
// Bench for axis_sa_out_transpose with R=2, C=2, WY=10.
// Input beats are written as {lane1, lane0}. For input beats b0={h0,l0} and
// b1={h1,l1}, beat 0 fills column 1 and beat 1 fills column 0. The expected
// output rows, written as {c1, c0}, are therefore row0={l0,l1} and
// row1={h0,h1}.

module tb_axis_sa_out_transpose;

  localparam int HALF = 5;

  logic             clk;
  logic             rst;
  logic             s_valid;
  logic             s_ready;
  logic             s_last;
  logic [1:0][9:0]  s_data;
  logic             m_valid;
  logic             m_ready;
  logic             m_last;
  logic [1:0][9:0]  m_data;
  logic             tile_err;

  int               testsRun;
  int               failCount;
  logic [20:0]      expQ[$];
  logic [20:0]      expBeat;
  logic [20:0]      prevBeat;
  bit               prevStall;
  longint           lastAcceptTime;
  longint           lastMlastTime;
  longint           t0;

  axis_sa_out_transpose #(.R(2), .C(2), .WY(10)) dut (
    .clk      (clk),
    .rst      (rst),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_last   (s_last),
    .s_data   (s_data),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_last   (m_last),
    .m_data   (m_data),
    .tile_err (tile_err)
  );

  initial clk = 1'b0;
  always #HALF clk = ~clk;

  function automatic logic [19:0] beat(input int hi, input int lo);
    return {hi[9:0], lo[9:0]};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic pushExp(input int c1, input int c0, input bit last);
    expQ.push_back({last, c1[9:0], c0[9:0]});
  endtask

  task automatic applyStimulus(input logic [19:0] d, input logic last);
    bit got;
    got     = 1'b0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (s_ready) begin
        got = 1'b1;
        break;
      end
    end
    if (got) begin
      @(posedge clk);
      lastAcceptTime = $time;
      #1;
    end
    testsRun++;
    if (!got) begin
      failCount++;
      $display("[TB] FAIL input_handshake: got timeout expected s_ready at %0t", $time);
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic waitIdle(input string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (expQ.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    checkOutput(name, {31'd0, done}, 32'd1);
  endtask

  // Output monitor: pops the scoreboard on every output handshake and checks
  // that a stalled beat is held steady while s_ready stays low during drain.
  always @(negedge clk) begin
    if (m_valid) begin
      checkOutput("s_ready_low_in_drain", {31'd0, s_ready}, 32'd0);
    end
    if (prevStall) begin
      checkOutput("stall_valid_held", {31'd0, m_valid}, 32'd1);
      checkOutput("stall_beat_held", {11'd0, m_last, m_data}, {11'd0, prevBeat});
    end
    if (m_valid && m_ready) begin
      if (expQ.size() == 0) begin
        testsRun++;
        failCount++;
        $display("[TB] FAIL unexpected_output: got %0h expected no beat", {m_last, m_data});
      end else begin
        expBeat = expQ.pop_front();
        checkOutput("out_beat", {11'd0, m_last, m_data}, {11'd0, expBeat});
      end
      if (m_last) lastMlastTime = $time + HALF;
    end
    prevStall = m_valid && !m_ready && !rst;
    prevBeat  = {m_last, m_data};
  end

  initial begin
    testsRun  = 0;
    failCount = 0;
    prevStall = 1'b0;
    rst       = 1'b1;
    s_valid   = 1'b0;
    s_last    = 1'b0;
    s_data    = '0;
    m_ready   = 1'b0;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_m_valid", {31'd0, m_valid}, 32'd0);
    checkOutput("rst_m_last", {31'd0, m_last}, 32'd0);
    checkOutput("rst_tile_err", {31'd0, tile_err}, 32'd0);
    checkOutput("rst_s_ready", {31'd0, s_ready}, 32'd0);
    rst = 1'b0;
    #1;
    checkOutput("post_rst_s_ready", {31'd0, s_ready}, 32'd1);

    // test 1: basic tile, m_ready always high
    m_ready = 1'b1;
    pushExp(5, -1, 1'b0);
    pushExp(-3, 7, 1'b1);
    applyStimulus(beat(-3, 5), 1'b0);
    applyStimulus(beat(7, -1), 1'b1);
    waitIdle("t1_drained");
    checkOutput("t1_tile_err", {31'd0, tile_err}, 32'd0);

    // test 2: same tile with downstream stalls
    m_ready = 1'b0;
    pushExp(5, -1, 1'b0);
    pushExp(-3, 7, 1'b1);
    applyStimulus(beat(-3, 5), 1'b0);
    applyStimulus(beat(7, -1), 1'b1);
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      m_ready = ~m_ready;
      if (expQ.size() == 0) break;
    end
    m_ready = 1'b1;
    waitIdle("t2_drained");

    // test 3: three back-to-back tiles, one tile per four cycles
    pushExp(2, 4, 1'b0);
    pushExp(1, 3, 1'b1);
    pushExp(6, 8, 1'b0);
    pushExp(-5, -7, 1'b1);
    pushExp(-100, 200, 1'b0);
    pushExp(100, -200, 1'b1);
    applyStimulus(beat(1, 2), 1'b0);
    t0 = lastAcceptTime;
    applyStimulus(beat(3, 4), 1'b1);
    applyStimulus(beat(-5, 6), 1'b0);
    applyStimulus(beat(-7, 8), 1'b1);
    applyStimulus(beat(100, -100), 1'b0);
    applyStimulus(beat(-200, 200), 1'b1);
    waitIdle("t3_drained");
    checkOutput("t3_throughput", 32'(lastMlastTime - t0), 32'(22 * HALF));
    checkOutput("t3_tile_err", {31'd0, tile_err}, 32'd0);

    // test 4: early s_last on the first beat zeroes the missing column
    pushExp(1, 0, 1'b0);
    pushExp(2, 0, 1'b1);
    applyStimulus(beat(2, 1), 1'b1);
    waitIdle("t4_drained");
    checkOutput("t4_tile_err_set", {31'd0, tile_err}, 32'd1);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("t4_tile_err_sticky", {31'd0, tile_err}, 32'd1);

    // test 5: reset after the first row aborts the tile
    m_ready = 1'b0;
    pushExp(12, 14, 1'b0);
    applyStimulus(beat(11, 12), 1'b0);
    applyStimulus(beat(13, 14), 1'b1);
    m_ready = 1'b1;
    @(posedge clk);
    #1;
    m_ready = 1'b0;
    rst     = 1'b1;
    #1;
    checkOutput("t5_s_ready_in_rst", {31'd0, s_ready}, 32'd0);
    @(posedge clk);
    #1;
    checkOutput("t5_m_valid_after_rst", {31'd0, m_valid}, 32'd0);
    checkOutput("t5_m_last_after_rst", {31'd0, m_last}, 32'd0);
    checkOutput("t5_tile_err_cleared", {31'd0, tile_err}, 32'd0);
    rst = 1'b0;
    #1;
    checkOutput("t5_s_ready_after_rst", {31'd0, s_ready}, 32'd1);
    m_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("t5_no_partial_tile", 32'(expQ.size()), 32'd0);

    // test 6: extreme values pass bit-exact
    pushExp(511, -512, 1'b0);
    pushExp(-512, 511, 1'b1);
    applyStimulus(beat(-512, 511), 1'b0);
    applyStimulus(beat(511, -512), 1'b1);
    waitIdle("t6_drained");
    checkOutput("t6_tile_err", {31'd0, tile_err}, 32'd0);

    // test 7: tile ends by count without s_last
    pushExp(8, 6, 1'b0);
    pushExp(9, 7, 1'b1);
    applyStimulus(beat(9, 8), 1'b0);
    applyStimulus(beat(7, 6), 1'b0);
    waitIdle("t7_drained");
    checkOutput("t7_tile_err_set", {31'd0, tile_err}, 32'd1);

    checkOutput("scoreboard_empty", 32'(expQ.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
